// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl
// Tracks the destination registers of in-flight instructions between
// decode and write-back, drives the register file write port from the
// final stage, picks operand-forwarding sources for decode and stalls
// decode on load-use hazards. The pipeline shifts on every edge; a
// stall only inserts a bubble at stage 0.
module riscv_hazard_ctrl #(
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         IssueValid_i,
   input  logic [ADDR_W-1:0]            IssueAddrD_i,
   input  logic                         IssueRegWEn_i,
   input  logic                         IssueIsLoad_i,
   input  logic [ADDR_W-1:0]            AddrA_i,
   input  logic [ADDR_W-1:0]            AddrB_i,
   input  logic                         UseA_i,
   input  logic                         UseB_i,
   input  logic                         Flush_i,
   output logic                         Stall_o,
   output logic [$clog2(DEPTH+1)-1:0]   FwdA_o,
   output logic [$clog2(DEPTH+1)-1:0]   FwdB_o,
   output logic                         WbRegWEn_o,
   output logic [ADDR_W-1:0]            WbAddrD_o,
   output logic [CNT_W-1:0]             StallCnt_o
);

   localparam int FWD_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              valid;
      logic              wen;
      logic              load;
      logic [ADDR_W-1:0] addr;
   } stgEntry_t;

   localparam stgEntry_t BUBBLE = '{valid: 1'b0, wen: 1'b0, load: 1'b0,
                                    addr: {ADDR_W{1'b0}}};

   stgEntry_t [DEPTH-1:0] stg_r;
   stgEntry_t [DEPTH-1:0] stgNext_s;
   stgEntry_t             issueEntry_s;
   logic                  issueAccept_s;
   logic [FWD_W:0]        lookA_s;
   logic [FWD_W:0]        lookB_s;
   logic                  stall_s;
   logic                  wbWen_r;
   logic [ADDR_W-1:0]     wbAddr_r;
   logic [CNT_W-1:0]      stallCnt_r;

   // Producer search for one source operand. Returns {hazard, fwd}.
   // Stages are scanned oldest to youngest so the youngest producer wins.
   // A load is only a hazard before it reaches the last stage, where its
   // data is available for forwarding. x0 never matches.
   function automatic logic [FWD_W:0] lookup(
      input stgEntry_t [DEPTH-1:0] stg,
      input logic                  useSrc,
      input logic [ADDR_W-1:0]     addr
   );
      logic [FWD_W-1:0] fwd;
      logic             haz;
      logic             hit;
      fwd = {FWD_W{1'b0}};
      haz = 1'b0;
      hit = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         hit = useSrc & (addr != {ADDR_W{1'b0}}) & stg[i].valid & stg[i].wen &
               (stg[i].addr == addr);
         fwd = hit ? FWD_W'(i + 1) : fwd;
         haz = hit ? (stg[i].load & (i < DEPTH - 1)) : haz;
      end
      return {haz, fwd};
   endfunction

   // Forwarding select and load-use stall; a flush overrides the stall.
   always_comb begin
      lookA_s = lookup(stg_r, UseA_i, AddrA_i);
      lookB_s = lookup(stg_r, UseB_i, AddrB_i);
      stall_s = ~Flush_i & (lookA_s[FWD_W] | lookB_s[FWD_W]);
   end

   // Next pipeline contents: accepted issue or bubble into stage 0,
   // everything else shifts; a flush turns the old stage 0 into a bubble.
   always_comb begin
      issueAccept_s      = IssueValid_i & ~stall_s & ~Flush_i;
      issueEntry_s.valid = 1'b1;
      issueEntry_s.wen   = IssueRegWEn_i & (IssueAddrD_i != {ADDR_W{1'b0}});
      issueEntry_s.load  = IssueIsLoad_i;
      issueEntry_s.addr  = IssueAddrD_i;
      stgNext_s          = {DEPTH{BUBBLE}};
      if (issueAccept_s) begin
         stgNext_s[0] = issueEntry_s;
      end else begin
         stgNext_s[0] = BUBBLE;
      end
      for (int i = 1; i < DEPTH; i++) begin
         stgNext_s[i] = ((i == 1) && Flush_i) ? BUBBLE : stg_r[i-1];
      end
   end

   // Stage register: reset discards every in-flight entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stg_r <= {DEPTH{BUBBLE}};
      end else begin
         stg_r <= stgNext_s;
      end
   end

   // Write-back port registers; the address holds while the last stage is empty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wbWen_r  <= 1'b0;
         wbAddr_r <= {ADDR_W{1'b0}};
      end else begin
         wbWen_r <= stgNext_s[DEPTH-1].valid & stgNext_s[DEPTH-1].wen;
         if (stgNext_s[DEPTH-1].valid) begin
            wbAddr_r <= stgNext_s[DEPTH-1].addr;
         end else begin
            wbAddr_r <= wbAddr_r;
         end
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stallCnt_r <= {CNT_W{1'b0}};
      end else if (stall_s && (stallCnt_r != {CNT_W{1'b1}})) begin
         stallCnt_r <= stallCnt_r + CNT_W'(1);
      end else begin
         stallCnt_r <= stallCnt_r;
      end
   end

   assign Stall_o    = stall_s;
   assign FwdA_o     = lookA_s[FWD_W-1:0];
   assign FwdB_o     = lookB_s[FWD_W-1:0];
   assign WbRegWEn_o = wbWen_r;
   assign WbAddrD_o  = wbAddr_r;
   assign StallCnt_o = stallCnt_r;

endmodule

// File: doc/riscv_hazard_ctrl.md
Name: riscv_hazard_ctrl

Overview:
Pipeline hazard controller that sequences the register file.
- Tracks destination registers of in-flight instructions across DEPTH stages between decode and write-back.
- Drives the register file's write-back address/enable at the final stage.
- Selects operand-forwarding sources and stalls decode on load-use hazards.
- Sits beside the register file, between decode and the EX/MEM/WB pipeline.

Parameters:
DEPTH, 3, number of in-flight stages from issue to register write-back (stage 0 = EX, DEPTH-1 = WB)
ADDR_W, 5, register address width
CNT_W, 16, width of stall performance counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
IssueValid_i  in  1  decode presents an instruction this cycle
IssueAddrD_i  in  ADDR_W  destination register of issuing instruction
IssueRegWEn_i  in  1  issuing instruction writes a register
IssueIsLoad_i  in  1  issuing instruction is a load (result valid only in stage DEPTH-1)
AddrA_i  in  ADDR_W  source A of decode instruction
AddrB_i  in  ADDR_W  source B of decode instruction
UseA_i  in  1  source A is read
UseB_i  in  1  source B is read
Flush_i  in  1  taken branch/jump: squash stage 0 and current issue
Stall_o  out  1  hold decode/fetch this cycle (combinational)
FwdA_o  out  $clog2(DEPTH+1)  0 = register file, k = forward from stage k-1 (combinational)
FwdB_o  out  $clog2(DEPTH+1)  same for source B
WbRegWEn_o  out  1  register file write enable (registered state of stage DEPTH-1)
WbAddrD_o  out  ADDR_W  register file write address (stage DEPTH-1)
StallCnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
Interface
- Single clock clk_i.
- Synchronous active-high reset rst_i.

Stage entries
- stg[i] = {valid, wen, load, addr}, i = 0..DEPTH-1.

Reset
- All stg[i].valid = 0.
- StallCnt_o = 0, WbRegWEn_o = 0, WbAddrD_o = 0.
- Consequently Stall_o = 0 and FwdA_o = FwdB_o = 0 in the cycle after reset.
- Reset mid-operation discards all in-flight entries; no write-back is emitted for them.

Shift (every non-reset edge; pipeline never freezes)
- stg[i] <= stg[i-1] for i >= 1.
- stg[0] <= issue entry if IssueValid_i & !Stall_o & !Flush_i, else bubble (valid = 0).
- Entry issued with IssueRegWEn_i = 0 or IssueAddrD_i = 0 is stored with wen = 0.

Flush
- Flush_i squashes stg[0]: it shifts into stg[1] as a bubble.
- Flush_i also squashes the current issue.
- Stages >= 1 are unaffected.

Write-back
- WbRegWEn_o = stg[DEPTH-1].valid & stg[DEPTH-1].wen.
- WbAddrD_o = stg[DEPTH-1].addr; held at last value when not valid.
- Latency from issue to write-back: exactly DEPTH edges.

Match (per source s in {A, B})
- match[i] = Use_s & (Addr_s != 0) & stg[i].valid & stg[i].wen & (stg[i].addr == Addr_s).
- Register x0 never matches.

Forwarding
- Fwd_s = j+1, where j = lowest index with match[j] (youngest producer wins).
- Fwd_s = 0 if no match.
- WB-stage match forwards (k = DEPTH), because the register file read is registered and does not see the same-cycle write.

Stall
- Stall_o = !Flush_i & OR over s of (youngest match j has stg[j].load = 1 and j < DEPTH-1).
- Flush_i has priority over stall.
- During stall, Fwd outputs are don't-care.
- Stall resolves automatically as the load advances (bubble inserted each stall cycle).

Counter
- StallCnt_o increments by 1 on each edge with Stall_o = 1.
- Saturates at 2^CNT_W - 1; no wrap.

Simultaneous events
- Issue + flush same cycle: issue squashed.
- Stall + issue: issue not accepted; decode must hold.

Test Plan:
- Reset then issue x5 (wen = 1, non-load) at cycle 0, bubbles after -> WbRegWEn_o = 1, WbAddrD_o = 5 exactly 3 edges later, 0 otherwise.
- Issue x7 ALU, next cycle decode reads A = x7 -> FwdA_o = 1, Stall_o = 0. One more cycle later -> FwdA_o = 2. Then -> FwdA_o = 3. Then -> FwdA_o = 0.
- Issue load x9, next cycle B = x9 -> Stall_o = 1 for 2 cycles, then Stall_o = 0 with FwdB_o = 3, StallCnt_o = 2.
- x3 written by stage 0 (ALU) and stage 2 simultaneously, A = x3 -> FwdA_o = 1 (youngest). Source A = x0 with x0 "in flight" -> FwdA_o = 0.
- Issue load x4, then Flush_i asserted with decode reading x4 -> Stall_o = 0, stg[0] squashed, no write-back of x4 appears 3 edges later.
- rst_i asserted while 3 valid writers in flight -> next cycle WbRegWEn_o = 0, StallCnt_o = 0, no write-backs emitted afterward. Separately, force 2^16 + 5 stall cycles -> StallCnt_o = 65535.
